fft_result_streamer: RTL and testbench

Reads the 64-point FFT result bank once the FFT core pulses `done`, snapshots all 64 complex bins into a local buffer, and streams them out one bin per transfer over a valid/ready interface in natural bin order (0..63). It sits directly downstream of the FFT core's parallel `outputRe`/`outputIm` buses. It frees the core for the next frame as soon as the snapshot is taken.

---
 rtl/fft_stream_pkg.sv | 25 ++
 rtl/fft_result_streamer_mag_sq.sv | 19 +
 rtl/fft_result_streamer.sv | 123 ++++++++++++
 tb/tb_fft_result_streamer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_stream_pkg.sv
// Shared constants and types for the FFT result streamer.
// Optional magnitude-squared output is enabled by FFT_STREAM_MAG_EN.
package fft_stream_pkg;

  localparam int unsigned D_WIDTH     = 64;
  localparam int unsigned LOG_2_WIDTH = 6;
  localparam int unsigned S_WIDTH     = 16;
  localparam int unsigned MAG_WIDTH   = 2 * S_WIDTH;

  typedef logic signed [S_WIDTH-1:0] sample_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

  // One complex bin as held in the snapshot buffer.
  typedef struct packed {
    sample_t re;
    sample_t im;
  } bin_t;

  localparam logic [LOG_2_WIDTH-1:0] LAST_INDEX = LOG_2_WIDTH'(D_WIDTH - 1);

endpackage

// File: rtl/fft_result_streamer_mag_sq.sv
// Squared magnitude of one complex bin: re*re + im*im, unsigned, never wraps.
// Only instantiated when FFT_STREAM_MAG_EN is defined.
module fft_mag_sq
  import fft_stream_pkg::*;
(
  input  sample_t                re_i,
  input  sample_t                im_i,
  output logic [MAG_WIDTH-1:0]   mag_o
);

  logic signed [MAG_WIDTH-1:0] re_sq;
  logic signed [MAG_WIDTH-1:0] im_sq;

  // Each square is at most 2^30, so the unsigned sum peaks at 2^31 and fits.
  assign re_sq = MAG_WIDTH'(re_i) * MAG_WIDTH'(re_i);
  assign im_sq = MAG_WIDTH'(im_i) * MAG_WIDTH'(im_i);
  assign mag_o = unsigned'(re_sq) + unsigned'(im_sq);

endmodule

// File: rtl/fft_result_streamer.sv
// Snapshots the 64 FFT result bins on done and streams them out in bin order.
// Define FFT_STREAM_MAG_EN to add the outMagSq output.
module fft_result_streamer
  import fft_stream_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               done,
  input  logic [D_WIDTH-1:0][S_WIDTH-1:0]    fftRe,
  input  logic [D_WIDTH-1:0][S_WIDTH-1:0]    fftIm,
  output logic                               outValid,
  input  logic                               outReady,
  output logic [S_WIDTH-1:0]                 outRe,
  output logic [S_WIDTH-1:0]                 outIm,
  output logic [LOG_2_WIDTH-1:0]             outIndex,
  output logic                               outLast,
  output logic                               busy,
  input  logic                               clrOverrun,
  output logic                               overrun
`ifdef FFT_STREAM_MAG_EN
  ,
  output logic [MAG_WIDTH-1:0]               outMagSq
`endif
);

  stream_state_t              state_q, state_d;
  logic [LOG_2_WIDTH-1:0]     index_q, index_d;
  logic                       overrun_q, overrun_d;
  bin_t                       buf_q [D_WIDTH];
  bin_t                       cur_bin;
  logic                       xfer;
  logic                       at_last;
  logic                       capture;
  logic                       ov_set;

  assign xfer    = (state_q == STREAM) && outReady;
  assign at_last = (index_q == LAST_INDEX);

  // Next-state: capture on done when idle or on the final transfer, else drop.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    ov_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (done) begin
          capture = 1'b1;
          index_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer && at_last) begin
          if (done) begin
            capture = 1'b1;
            index_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            index_d = index_q + LOG_2_WIDTH'(1);
          end
          if (done) begin
            ov_set = 1'b1;
          end
        end
      end
    endcase
    if (ov_set) begin
      overrun_d = 1'b1;
    end else if (clrOverrun) begin
      overrun_d = 1'b0;
    end
  end

  // Control state, updated on the falling edge to match the FFT core.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      index_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      overrun_q <= overrun_d;
    end
  end

  // Snapshot buffer; loaded in one edge so the core is free immediately.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(D_WIDTH); i++) begin
        buf_q[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < int'(D_WIDTH); i++) begin
        buf_q[i].re <= sample_t'(fftRe[i]);
        buf_q[i].im <= sample_t'(fftIm[i]);
      end
    end
  end

  assign cur_bin  = buf_q[index_q];
  assign outValid = (state_q == STREAM);
  assign busy     = (state_q == STREAM);
  assign outRe    = cur_bin.re;
  assign outIm    = cur_bin.im;
  assign outIndex = index_q;
  assign outLast  = (state_q == STREAM) && at_last;
  assign overrun  = overrun_q;

`ifdef FFT_STREAM_MAG_EN
  fft_mag_sq u_mag_sq (
    .re_i  (cur_bin.re),
    .im_i  (cur_bin.im),
    .mag_o (outMagSq)
  );
`endif

endmodule

// File: tb/tb_fft_result_streamer.sv
// Directed self-checking bench for fft_result_streamer (FFT_STREAM_MAG_EN adds magnitude checks).
module tb_fft_result_streamer;

  logic              clk;
  logic              rst;
  logic              done;
  logic [63:0][15:0] fftRe;
  logic [63:0][15:0] fftIm;
  logic              outValid;
  logic              outReady;
  logic [15:0]       outRe;
  logic [15:0]       outIm;
  logic [5:0]        outIndex;
  logic              outLast;
  logic              busy;
  logic              clrOverrun;
  logic              overrun;
`ifdef FFT_STREAM_MAG_EN
  logic [31:0]       outMagSq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fft_result_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .done       (done),
    .fftRe      (fftRe),
    .fftIm      (fftIm),
    .outValid   (outValid),
    .outReady   (outReady),
    .outRe      (outRe),
    .outIm      (outIm),
    .outIndex   (outIndex),
    .outLast    (outLast),
    .busy       (busy),
    .clrOverrun (clrOverrun),
    .overrun    (overrun)
`ifdef FFT_STREAM_MAG_EN
    ,
    .outMagSq   (outMagSq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(posedge clk);
    n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", outValid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    n_tests++; if (outRe !== 16'h0 || outIm !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h/%h exp 0/0", outRe, outIm); end
    n_tests++; if (outIndex !== 6'd0 || outLast !== 1'b0) begin n_fail++; $display("FAIL reset_index got %0d last %b exp 0/0", outIndex, outLast); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    outReady = 1'b1;
    for (int i = 0; i < 64; i++) begin
      fftRe[i] = 16'(i);
      fftIm[i] = 16'(-i);
    end
    @(posedge clk); done = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); done = 1'b0;
      n_tests++; if (outValid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_valid i=%0d got v%b b%b exp 1/1", i, outValid, busy); end
      n_tests++; if (outIndex !== 6'(i)) begin n_fail++; $display("FAIL basic_index got %0d exp %0d", outIndex, i); end
      n_tests++; if (outRe !== 16'(i) || outIm !== 16'(-i)) begin n_fail++; $display("FAIL basic_data i=%0d got %h/%h exp %h/%h", i, outRe, outIm, 16'(i), 16'(-i)); end
      n_tests++; if (outLast !== (i == 63)) begin n_fail++; $display("FAIL basic_last i=%0d got %b exp %b", i, outLast, (i == 63)); end
    end
    @(posedge clk);
    n_tests++; if (outValid !== 1'b0 || busy !== 1'b0 || outLast !== 1'b0) begin n_fail++; $display("FAIL basic_end got v%b b%b l%b exp 0/0/0", outValid, busy, outLast); end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int exp_idx;
    int last_seen;
    pat = 4'b1001;
    exp_idx = 0;
    last_seen = -1;
    outReady = 1'b0;
    for (int i = 0; i < 64; i++) begin
      fftRe[i] = 16'(i + 100);
      fftIm[i] = 16'(i * 3);
    end
    @(posedge clk); done = 1'b1;
    for (int cyc = 0; cyc < 400 && exp_idx < 64; cyc++) begin
      @(posedge clk); done = 1'b0;
      n_tests++; if (outValid !== 1'b1 || outIndex !== 6'(exp_idx)) begin n_fail++; $display("FAIL bp_index cyc=%0d got v%b %0d exp 1 %0d", cyc, outValid, outIndex, exp_idx); end
      n_tests++; if (outRe !== 16'(exp_idx + 100) || outIm !== 16'(exp_idx * 3)) begin n_fail++; $display("FAIL bp_data cyc=%0d got %h/%h exp %h/%h", cyc, outRe, outIm, 16'(exp_idx + 100), 16'(exp_idx * 3)); end
      n_tests++; if (outLast !== (exp_idx == 63)) begin n_fail++; $display("FAIL bp_last cyc=%0d got %b exp %b", cyc, outLast, (exp_idx == 63)); end
      outReady = pat[cyc % 4];
      if (outReady) begin
        last_seen = int'(outIndex);
        exp_idx++;
      end
    end
    n_tests++; if (exp_idx != 64 || last_seen != 63) begin n_fail++; $display("FAIL bp_final got count %0d last %0d exp 64 63", exp_idx, last_seen); end
    @(posedge clk); outReady = 1'b1;
    n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid got %b exp 0", outValid); end
  endtask

  task automatic test_overrun();
    outReady = 1'b1;
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_initial got %b exp 0", overrun); end
    for (int i = 0; i < 64; i++) begin
      fftRe[i] = 16'(i);
      fftIm[i] = 16'(-i);
    end
    @(posedge clk); done = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); done = 1'b0; clrOverrun = 1'b0;
      n_tests++; if (outValid !== 1'b1 || outIndex !== 6'(i)) begin n_fail++; $display("FAIL ovr_index got v%b %0d exp 1 %0d", outValid, outIndex, i); end
      n_tests++; if (outRe !== 16'(i) || outIm !== 16'(-i)) begin n_fail++; $display("FAIL ovr_data i=%0d got %h/%h exp %h/%h", i, outRe, outIm, 16'(i), 16'(-i)); end
      if (i == 10) begin
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre got %b exp 0", overrun); end
        for (int k = 0; k < 64; k++) begin
          fftRe[k] = 16'h7FFF;
          fftIm[k] = 16'h7FFF;
        end
        done = 1'b1;
      end
      if (i == 11) begin
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b exp 1", overrun); end
      end
      if (i == 20) begin
        done = 1'b1;
        clrOverrun = 1'b1;
      end
      if (i == 21) begin
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins got %b exp 1", overrun); end
      end
    end
    @(posedge clk);
    n_tests++; if (outValid !== 1'b0 || overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_end got v%b o%b exp 0/1", outValid, overrun); end
    clrOverrun = 1'b1;
    @(posedge clk); clrOverrun = 1'b0;
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b exp 0", overrun); end
  endtask

  task automatic test_back_to_back();
    outReady = 1'b1;
    for (int i = 0; i < 64; i++) begin
      fftRe[i] = 16'(i + 200);
      fftIm[i] = 16'd7;
    end
    @(posedge clk); done = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); done = 1'b0;
      n_tests++; if (outValid !== 1'b1 || outIndex !== 6'(i) || outRe !== 16'(i + 200)) begin n_fail++; $display("FAIL b2b_a i=%0d got v%b %0d %h", i, outValid, outIndex, outRe); end
      if (i == 63) begin
        for (int k = 0; k < 64; k++) begin
          fftRe[k] = 16'(k + 500);
          fftIm[k] = 16'(-9);
        end
        done = 1'b1;
      end
    end
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); done = 1'b0;
      n_tests++; if (outValid !== 1'b1 || outIndex !== 6'(i)) begin n_fail++; $display("FAIL b2b_b_index got v%b %0d exp 1 %0d", outValid, outIndex, i); end
      n_tests++; if (outRe !== 16'(i + 500) || outIm !== 16'(-9)) begin n_fail++; $display("FAIL b2b_b_data i=%0d got %h/%h exp %h/%h", i, outRe, outIm, 16'(i + 500), 16'(-9)); end
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun i=%0d got %b exp 0", i, overrun); end
    end
    @(posedge clk);
    n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b exp 0", outValid); end
  endtask

  task automatic test_reset_mid();
    outReady = 1'b1;
    for (int i = 0; i < 64; i++) begin
      fftRe[i] = 16'(i + 1);
      fftIm[i] = 16'(i);
    end
    @(posedge clk); done = 1'b1;
    for (int i = 0; i <= 30; i++) begin
      @(posedge clk); done = 1'b0;
      if (i == 5) done = 1'b1;
      if (i == 30) begin
        n_tests++; if (outIndex !== 6'd30 || overrun !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got %0d o%b exp 30 1", outIndex, overrun); end
        rst = 1'b0;
        #1;
        n_tests++; if (outValid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rmid_flags got v%b b%b o%b exp 0/0/0", outValid, busy, overrun); end
        n_tests++; if (outRe !== 16'h0 || outIm !== 16'h0 || outIndex !== 6'd0 || outLast !== 1'b0) begin n_fail++; $display("FAIL rmid_data got %h/%h %0d l%b exp 0", outRe, outIm, outIndex, outLast); end
      end
    end
    @(posedge clk); rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      n_tests++; if (outValid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_idle k=%0d got v%b b%b exp 0/0", k, outValid, busy); end
    end
    for (int i = 0; i < 64; i++) fftRe[i] = 16'(i + 40);
    done = 1'b1;
    @(posedge clk); done = 1'b0;
    n_tests++; if (outValid !== 1'b1 || outIndex !== 6'd0 || outRe !== 16'd40) begin n_fail++; $display("FAIL rmid_restart got v%b %0d %h exp 1 0 0028", outValid, outIndex, outRe); end
    for (int i = 0; i < 70 && outValid; i++) @(posedge clk);
    n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL rmid_drain got %b exp 0", outValid); end
  endtask

`ifdef FFT_STREAM_MAG_EN
  task automatic test_mag();
    logic [31:0] exp_mag [4];
    exp_mag[0] = 32'd25;
    exp_mag[1] = 32'd2147483648;
    exp_mag[2] = 32'd2147352578;
    exp_mag[3] = 32'd25;
    outReady = 1'b1;
    for (int i = 0; i < 64; i++) begin
      fftRe[i] = 16'h0;
      fftIm[i] = 16'h0;
    end
    fftRe[0] = 16'd3;     fftIm[0] = 16'hFFFC;
    fftRe[1] = 16'h8000;  fftIm[1] = 16'h8000;
    fftRe[2] = 16'h7FFF;  fftIm[2] = 16'h7FFF;
    fftRe[3] = 16'hFFFB;  fftIm[3] = 16'h0;
    @(posedge clk); done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); done = 1'b0;
      n_tests++; if (outMagSq !== exp_mag[i]) begin n_fail++; $display("FAIL mag i=%0d got %0d exp %0d", i, outMagSq, exp_mag[i]); end
    end
    for (int i = 0; i < 70 && outValid; i++) @(posedge clk);
    n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL mag_drain got %b exp 0", outValid); end
  endtask
`endif

  initial begin
    rst = 1'b0;
    done = 1'b0;
    outReady = 1'b0;
    clrOverrun = 1'b0;
    fftRe = '0;
    fftIm = '0;
    @(posedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef FFT_STREAM_MAG_EN
    test_mag();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
